image_bank_streamer: RTL and testbench

IMAGE_BANK_STREAMER -- requirements
Module: image_bank_streamer

---
 rtl/image_bank_streamer.sv | 152 +++++++++++++++
 tb/tb_image_bank_streamer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_bank_streamer.sv
// Streams one frame from a bank of image ROMs sharing one address bus.
// Reads are credit-limited so the small output FIFO can never overflow.
module image_bank_streamer #(
    parameter int NUM_IMG = 3,
    parameter int PIX_W   = 24,
    parameter int ADDR_W  = 17,
    parameter int DEPTH   = 76800,
    parameter int RD_LAT  = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NUM_IMG-1:0]       sel_im,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [NUM_IMG*PIX_W-1:0] rom_q,
    output logic [PIX_W-1:0]         pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     pix_sof,
    output logic                     pix_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     sel_err
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FD = RD_LAT + 1;
    localparam int PW = $clog2(FD);
    localparam int NW = $clog2(FD + 1);
    localparam int SW = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      rd_cnt;
    logic [CW-1:0]      beat_cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [SW-1:0]      sel_idx;
    logic [SW-1:0]      sel_enc;
    logic               sel_ok;
    logic [RD_LAT-1:0]  pvld;
    logic [PIX_W-1:0]   mem [FD];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [NW-1:0]      cnt;
    logic [NW-1:0]      inflight;
    logic [3:0]         occ;
    logic               issue;
    logic               pop;
    logic               wr;
    logic               last_beat;
    logic [PIX_W-1:0]   rd_word;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Read credit, select decode and output qualifiers.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + NW'(pvld[i]);
        pop       = pix_valid && pix_ready;
        wr        = pvld[RD_LAT-1];
        occ       = 4'(cnt) + 4'(inflight) - 4'(pop);
        issue     = (state == RUN) && (occ < 4'(FD));
        last_beat = pop && (beat_cnt == CW'(DEPTH - 1));
        sel_ok    = $onehot(sel_im);
        sel_enc   = '0;
        for (int i = 0; i < NUM_IMG; i++)
            if (sel_im[i]) sel_enc = SW'(i);
        rd_word   = rom_q[sel_idx*PIX_W +: PIX_W];
        rom_addr  = issue ? ADDR_W'(rd_cnt) : addr_q;
        pix_valid = (cnt != '0);
        pix_data  = mem[rd_ptr];
        pix_sof   = pix_valid && (beat_cnt == '0);
        pix_last  = pix_valid && (beat_cnt == CW'(DEPTH - 1));
    end

    // Frame sequencing: latch select, issue reads, wait for the last beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            addr_q     <= '0;
            sel_idx    <= '0;
            sel_err    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        rd_cnt  <= '0;
                        sel_idx <= sel_ok ? sel_enc : '0;
                        if (!sel_ok) sel_err <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q <= ADDR_W'(rd_cnt);
                        if (rd_cnt == CW'(DEPTH - 1))
                            state <= DRAIN;
                        else
                            rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return tracking, output FIFO and beat position.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pvld     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < FD; i++) mem[i] <= '0;
        end else begin
            pvld[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pvld[i] <= pvld[i-1];
            if (wr) begin
                mem[wr_ptr] <= rd_word;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= nxt(rd_ptr);
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (wr && !pop)      cnt <= cnt + 1'b1;
            else if (!wr && pop) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_image_bank_streamer.sv
// Bench for image_bank_streamer: three instances (latency 1, latency 2,
// single-pixel frame) driven one at a time against a frame-level model.
module tb_image_bank_streamer;

    logic        clk;
    logic        rst_n;
    logic        start_s;
    logic        ready_s;
    logic [2:0]  sel_s;
    int          d;
    int          checks;
    int          passes;
    bit          err_model [3];
    logic [23:0] rom [3][16];
    logic        start_w [3];
    logic        ready_w [3];
    logic [71:0] q_w [3];
    logic [71:0] qb1;
    logic [16:0] addr_w [3];
    logic [23:0] data_w [3];
    logic        valid_w [3];
    logic        sof_w [3];
    logic        last_w [3];
    logic        busy_w [3];
    logic        fd_w [3];
    logic        serr_w [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            start_w[k] = start_s && (d == k);
            ready_w[k] = (d == k) ? ready_s : 1'b1;
        end
    end

    function automatic logic [71:0] pack(input logic [16:0] a);
        logic [71:0] v;
        for (int i = 0; i < 3; i++) v[i*24 +: 24] = rom[i][a[3:0]];
        return v;
    endfunction

    always @(posedge clk) begin
        q_w[0] <= pack(addr_w[0]);
        qb1    <= pack(addr_w[1]);
        q_w[1] <= qb1;
        q_w[2] <= pack(addr_w[2]);
    end

    image_bank_streamer #(.NUM_IMG(3), .PIX_W(24), .ADDR_W(17),
                          .DEPTH(16), .RD_LAT(1)) u_a (
        .clock(clk), .reset_n(rst_n), .start(start_w[0]),
        .sel_im(sel_s), .rom_addr(addr_w[0]), .rom_q(q_w[0]),
        .pix_data(data_w[0]), .pix_valid(valid_w[0]),
        .pix_ready(ready_w[0]), .pix_sof(sof_w[0]),
        .pix_last(last_w[0]), .busy(busy_w[0]),
        .frame_done(fd_w[0]), .sel_err(serr_w[0]));

    image_bank_streamer #(.NUM_IMG(3), .PIX_W(24), .ADDR_W(17),
                          .DEPTH(16), .RD_LAT(2)) u_b (
        .clock(clk), .reset_n(rst_n), .start(start_w[1]),
        .sel_im(sel_s), .rom_addr(addr_w[1]), .rom_q(q_w[1]),
        .pix_data(data_w[1]), .pix_valid(valid_w[1]),
        .pix_ready(ready_w[1]), .pix_sof(sof_w[1]),
        .pix_last(last_w[1]), .busy(busy_w[1]),
        .frame_done(fd_w[1]), .sel_err(serr_w[1]));

    image_bank_streamer #(.NUM_IMG(3), .PIX_W(24), .ADDR_W(17),
                          .DEPTH(1), .RD_LAT(1)) u_c (
        .clock(clk), .reset_n(rst_n), .start(start_w[2]),
        .sel_im(sel_s), .rom_addr(addr_w[2]), .rom_q(q_w[2]),
        .pix_data(data_w[2]), .pix_valid(valid_w[2]),
        .pix_ready(ready_w[2]), .pix_sof(sof_w[2]),
        .pix_last(last_w[2]), .busy(busy_w[2]),
        .frame_done(fd_w[2]), .sel_err(serr_w[2]));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, addr_w[d], 0);
        chk({tag, "_data"}, data_w[d], 0);
        chk({tag, "_valid"}, valid_w[d], 0);
        chk({tag, "_sof"}, sof_w[d], 0);
        chk({tag, "_last"}, last_w[d], 0);
        chk({tag, "_busy"}, busy_w[d], 0);
        chk({tag, "_fd"}, fd_w[d], 0);
        chk({tag, "_serr"}, serr_w[d], 0);
    endtask

    // mode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready
    task automatic run(input logic [2:0] sel, input int mode,
                       input bit mid_sel, input bit mid_start,
                       input int abort_at, input bit chain);
        int depth, lat, img, nbeat, first, fdn, c;
        bit stalled, done;
        logic [23:0] hd;
        logic hs, hl;
        depth = (d == 2) ? 1 : 16;
        lat = (d == 1) ? 2 : 1;
        img = 0;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 3; i++) if (sel[i]) img = i;
        end else begin
            err_model[d] = 1'b1;
        end
        nbeat = 0; first = -1; fdn = 0;
        stalled = 0; done = 0;
        hd = '0; hs = 0; hl = 0;
        sel_s = sel;
        start_s = 1'b1;
        @(negedge clk);
        for (c = 1; c < 400 && !done; c++) begin
            start_s = mid_start && (c == 6);
            if (mid_sel && c == 5) sel_s = 3'b100;
            case (mode)
                0: ready_s = 1'b1;
                1: ready_s = (c % 4 == 0) || (c % 4 == 3);
                default: ready_s = 1'($urandom_range(0, 1));
            endcase
            if (c == 1) chk("sel_err", serr_w[d], err_model[d]);
            if (mode == 0 && c <= lat + 2)
                chk("first_valid", valid_w[d], c == lat + 2);
            if (fd_w[d]) fdn++;
            if (stalled) begin
                chk("stall_valid", valid_w[d], 1);
                chk("stall_data", data_w[d], hd);
                chk("stall_sof", sof_w[d], hs);
                chk("stall_last", last_w[d], hl);
            end
            stalled = 0;
            chk("addr_range", addr_w[d] < 17'(depth), 1);
            chk("busy", busy_w[d], 1);
            if (valid_w[d] && ready_s) begin
                chk("data", data_w[d], rom[img][nbeat]);
                chk("sof", sof_w[d], nbeat == 0);
                chk("last", last_w[d], nbeat == depth - 1);
                if (mode == 0 && first >= 0) chk("rate", c, first + nbeat);
                if (first < 0) first = c;
                if (nbeat == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero("rst");
                    for (int k = 0; k < 3; k++) err_model[k] = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("post_rst_valid", valid_w[d], 0);
                        chk("post_rst_busy", busy_w[d], 0);
                    end
                    start_s = 1'b0;
                    return;
                end
                nbeat++;
                if (nbeat == depth) done = 1;
            end else if (valid_w[d]) begin
                stalled = 1;
                hd = data_w[d];
                hs = sof_w[d];
                hl = last_w[d];
            end
            @(negedge clk);
        end
        start_s = 1'b0;
        if (!done) begin
            chk("timeout", 0, 1);
        end else begin
            chk("frame_done", fd_w[d], 1);
            chk("done_busy", busy_w[d], 0);
            chk("early_fd", fdn, 0);
        end
        if (!chain) begin
            repeat (3) begin
                @(negedge clk);
                chk("idle_fd", fd_w[d], 0);
                chk("idle_busy", busy_w[d], 0);
                chk("idle_valid", valid_w[d], 0);
                chk("idle_addr", addr_w[d], depth - 1);
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 1'b0;
        d = 0;
        start_s = 1'b0;
        ready_s = 1'b1;
        sel_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            err_model[k] = 1'b0;
            for (int a = 0; a < 16; a++) rom[k][a] = 24'($urandom);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            d = k;
            chk_zero("reset");
        end
        d = 0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("boot_valid", valid_w[0], 0);
            chk("boot_busy", busy_w[0], 0);
        end
        run(3'b010, 0, 0, 0, -1, 0);
        run(3'b010, 1, 0, 0, -1, 0);
        run(3'b110, 0, 1, 0, -1, 0);
        run(3'b001, 0, 0, 1, -1, 0);
        run(3'b100, 0, 0, 0, -1, 1);
        run(3'b010, 0, 0, 0, -1, 0);
        run(3'b010, 0, 0, 0, 7, 0);
        run(3'b001, 0, 0, 0, -1, 0);
        d = 1;
        run(3'b010, 0, 0, 0, -1, 0);
        run(3'b100, 1, 0, 0, -1, 0);
        d = 2;
        run(3'b010, 0, 0, 0, -1, 0);
        run(3'b000, 1, 0, 0, -1, 0);
        for (int k = 0; k < 6; k++) begin
            d = k % 3;
            run(3'($urandom_range(0, 7)), 2, 0, 0, -1, 0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
